// File: rtl/tlb_op_sequencer_if.sv
// Handshake and TLB port bundle between EXE/CSR/mmu and the TLB op sequencer.
// slave: sequencer view; master: the surrounding pipeline and TLB.
interface tlb_op_sequencer_if #(
   parameter int TLBNUM = 16
);
   localparam int IDXW = $clog2(TLBNUM);

   logic            op_valid;
   logic            op_ready;
   logic [2:0]      op_code;
   logic            flush;
   logic [4:0]      inv_op;
   logic [9:0]      inv_asid;
   logic [18:0]     inv_vppn;
   logic [18:0]     csr_vppn;
   logic [9:0]      csr_asid;
   logic [IDXW-1:0] csr_index;

   logic            s1_sel;
   logic [18:0]     s1_vppn;
   logic            s1_va_bit12;
   logic [9:0]      s1_asid;
   logic            s1_found;
   logic [IDXW-1:0] s1_index;

   logic [IDXW-1:0] r_index;
   logic            we;
   logic [IDXW-1:0] w_index;
   logic            invtlb_valid;
   logic [4:0]      invtlb_op;

   logic            done_valid;
   logic [2:0]      done_op;
   logic            done_found;
   logic [IDXW-1:0] done_index;
   logic            done_ine;

   modport slave (
      input  op_valid, op_code, flush, inv_op, inv_asid, inv_vppn,
             csr_vppn, csr_asid, csr_index, s1_found, s1_index,
      output op_ready, s1_sel, s1_vppn, s1_va_bit12, s1_asid,
             r_index, we, w_index, invtlb_valid, invtlb_op,
             done_valid, done_op, done_found, done_index, done_ine
   );

   modport master (
      output op_valid, op_code, flush, inv_op, inv_asid, inv_vppn,
             csr_vppn, csr_asid, csr_index, s1_found, s1_index,
      input  op_ready, s1_sel, s1_vppn, s1_va_bit12, s1_asid,
             r_index, we, w_index, invtlb_valid, invtlb_op,
             done_valid, done_op, done_found, done_index, done_ine
   );
endinterface

// File: rtl/tlb_op_sequencer.sv
// Sequences tlbsrch/tlbrd/tlbwr/tlbfill/invtlb; TLB_FILL_LFSR_EN selects an LFSR fill index.
// Accept at T, TLB ports at T+1, done pulse at T+2; op_ready low while busy, flush ignored after accept.
module tlb_op_sequencer #(
   parameter int TLBNUM = 16
) (
   input  logic                clk,
   input  logic                resetn,
   tlb_op_sequencer_if.slave   bus
);
   localparam int IDXW = $clog2(TLBNUM);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   logic [1:0]      r_state;
   logic [2:0]      r_op;
   logic [4:0]      r_inv_op;
   logic [9:0]      r_inv_asid;
   logic [18:0]     r_inv_vppn;
   logic [18:0]     r_csr_vppn;
   logic [9:0]      r_csr_asid;
   logic [IDXW-1:0] r_idx;
   logic            r_found;
   logic [IDXW-1:0] r_hit_idx;

   logic            w_accept;
   logic            w_exec;
   logic            w_resp;
   logic            w_s1_own;
   logic            w_is_inv;
   logic            w_inv_legal;
   logic            w_is_write;
   logic            w_reserved;
   logic [IDXW-1:0] w_fill_idx;

   assign w_accept    = (r_state == S_IDLE) && bus.op_valid && !bus.flush;
   assign w_exec      = (r_state == S_EXEC);
   assign w_resp      = (r_state == S_RESP);
   assign w_is_inv    = (r_op == OP_INV);
   assign w_inv_legal = (r_inv_op <= 5'd6);
   assign w_is_write  = (r_op == OP_WR) || (r_op == OP_FILL);
   assign w_reserved  = (r_op > OP_INV);
   assign w_s1_own    = w_exec && ((r_op == OP_SRCH) || w_is_inv);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_accept) r_state <= S_EXEC;
            S_EXEC:  r_state <= S_RESP;
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Operands are frozen at accept so late CSR writes or a flush cannot disturb the op.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_op       <= '0;
         r_inv_op   <= '0;
         r_inv_asid <= '0;
         r_inv_vppn <= '0;
         r_csr_vppn <= '0;
         r_csr_asid <= '0;
         r_idx      <= '0;
         r_found    <= 1'b0;
         r_hit_idx  <= '0;
      end else begin
         if (w_accept) begin
            r_op       <= bus.op_code;
            r_inv_op   <= bus.inv_op;
            r_inv_asid <= bus.inv_asid;
            r_inv_vppn <= bus.inv_vppn;
            r_csr_vppn <= bus.csr_vppn;
            r_csr_asid <= bus.csr_asid;
            r_idx      <= (bus.op_code == OP_FILL) ? w_fill_idx : bus.csr_index;
         end
         if (w_exec && (r_op == OP_SRCH)) begin
            r_found   <= bus.s1_found;
            r_hit_idx <= bus.s1_index;
         end
      end
   end

`ifdef TLB_FILL_LFSR_EN
   logic [7:0] r_lfsr;

   // x^8+x^6+x^5+x^4+1, Fibonacci form, advancing every cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_lfsr <= 8'h01;
      end else begin
         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      end
   end

   assign w_fill_idx = r_lfsr[IDXW-1:0];
`else
   logic [IDXW-1:0] r_fill_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fill_cnt <= '0;
      end else if (r_fill_cnt == IDXW'(TLBNUM - 1)) begin
         r_fill_cnt <= '0;
      end else begin
         r_fill_cnt <= r_fill_cnt + 1'b1;
      end
   end

   assign w_fill_idx = r_fill_cnt;
`endif

   // All outputs decode from registered state so reset clears them without waiting for a clock.
   assign bus.op_ready     = resetn && (r_state == S_IDLE);

   assign bus.s1_sel       = w_s1_own;
   assign bus.s1_vppn      = !w_s1_own ? '0 : (w_is_inv ? r_inv_vppn : r_csr_vppn);
   assign bus.s1_asid      = !w_s1_own ? '0 : (w_is_inv ? r_inv_asid : r_csr_asid);
   assign bus.s1_va_bit12  = 1'b0;

   assign bus.r_index      = r_idx;
   assign bus.we           = w_exec && w_is_write;
   assign bus.w_index      = (w_exec && w_is_write) ? r_idx : '0;
   assign bus.invtlb_valid = w_exec && w_is_inv && w_inv_legal;
   assign bus.invtlb_op    = (w_exec && w_is_inv && w_inv_legal) ? r_inv_op : '0;

   assign bus.done_valid   = w_resp;
   assign bus.done_op      = w_resp ? r_op : '0;
   assign bus.done_found   = w_resp && (r_op == OP_SRCH) && r_found;
   assign bus.done_index   = (w_resp && (r_op == OP_SRCH)) ? r_hit_idx : '0;
   assign bus.done_ine     = w_resp && (w_reserved || (w_is_inv && !w_inv_legal));
endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Bench for tlb_op_sequencer: directed literal cases, then random ops against a window-indexed model.
// The model tracks which cycle holds the accepted op's EXEC and RESP and derives every output from that.
module tb_tlb_op_sequencer;
   localparam int TLBNUM = 16;
   localparam int IDXW   = $clog2(TLBNUM);

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   tlb_op_sequencer_if #(.TLBNUM(TLBNUM)) bus ();
   tlb_op_sequencer #(.TLBNUM(TLBNUM)) dut (.clk(clk), .resetn(resetn), .bus(bus));

   int errors = 0;
   int checks = 0;

   logic [18:0] tlb_vppn [TLBNUM];
   logic [9:0]  tlb_asid [TLBNUM];

   function automatic logic [IDXW:0] lookup(input logic [18:0] v, input logic [9:0] a);
      logic [IDXW:0] res;
      res = '0;
      for (int i = TLBNUM - 1; i >= 0; i--)
         if (tlb_vppn[i] == v && tlb_asid[i] == a) res = {1'b1, IDXW'(i)};
      return res;
   endfunction

   assign {bus.s1_found, bus.s1_index} = lookup(bus.s1_vppn, bus.s1_asid);

   function automatic logic [IDXW-1:0] fill_at(input int n);
`ifdef TLB_FILL_LFSR_EN
      logic [7:0] l;
      l = 8'h01;
      repeat (n) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      return l[IDXW-1:0];
`else
      return IDXW'(n % TLBNUM);
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: w counts cycles since reset release; the accepted op is in EXEC during window exec_w.
   int          w = 0;
   int          exec_w = -10;
   logic [2:0]  m_op;
   logic [4:0]  m_inv_op;
   logic [9:0]  m_inv_asid, m_asid;
   logic [18:0] m_inv_vppn, m_vppn;
   logic [IDXW-1:0] m_idx, m_hidx;
   logic        m_found;

   always @(negedge clk) begin
      logic ex, rs, own, inv_ok, wr;
      logic [IDXW:0] lk;
      if (!resetn) begin
         chk("reset_quiet", {bus.op_ready, bus.s1_sel, bus.s1_vppn, bus.s1_va_bit12, bus.s1_asid,
                             bus.r_index, bus.we, bus.w_index, bus.invtlb_valid, bus.invtlb_op,
                             bus.done_valid, bus.done_op, bus.done_found, bus.done_index, bus.done_ine}, 64'd0);
         w = 0; exec_w = -10;
         m_op = '0; m_inv_op = '0; m_inv_asid = '0; m_asid = '0; m_inv_vppn = '0; m_vppn = '0;
         m_idx = '0; m_hidx = '0; m_found = 1'b0;
      end else begin
         ex     = (w == exec_w);
         rs     = (w == exec_w + 1);
         own    = ex && (m_op == 3'd0 || m_op == 3'd4);
         inv_ok = ex && m_op == 3'd4 && m_inv_op <= 5'd6;
         wr     = ex && (m_op == 3'd2 || m_op == 3'd3);
         chk("m_op_ready", bus.op_ready, !ex && !rs);
         chk("m_s1_sel", bus.s1_sel, own);
         chk("m_s1_vppn", bus.s1_vppn, own ? (m_op == 3'd4 ? m_inv_vppn : m_vppn) : 19'd0);
         chk("m_s1_asid", bus.s1_asid, own ? (m_op == 3'd4 ? m_inv_asid : m_asid) : 10'd0);
         chk("m_s1_bit12", bus.s1_va_bit12, 1'b0);
         chk("m_r_index", bus.r_index, m_idx);
         chk("m_we", bus.we, wr);
         chk("m_w_index", bus.w_index, wr ? m_idx : '0);
         chk("m_inv_valid", bus.invtlb_valid, inv_ok);
         chk("m_inv_op", bus.invtlb_op, inv_ok ? m_inv_op : 5'd0);
         chk("m_done_valid", bus.done_valid, rs);
         chk("m_done_op", bus.done_op, rs ? m_op : 3'd0);
         chk("m_done_found", bus.done_found, rs && m_op == 3'd0 && m_found);
         chk("m_done_index", bus.done_index, (rs && m_op == 3'd0) ? m_hidx : '0);
         chk("m_done_ine", bus.done_ine, rs && (m_op > 3'd4 || (m_op == 3'd4 && m_inv_op > 5'd6)));
         if (ex && m_op == 3'd0) begin
            lk = lookup(m_vppn, m_asid);
            m_found = lk[IDXW];
            m_hidx  = lk[IDXW-1:0];
         end
         if (!ex && !rs && bus.op_valid && !bus.flush) begin
            exec_w     = w + 1;
            m_op       = bus.op_code;
            m_inv_op   = bus.inv_op;
            m_inv_asid = bus.inv_asid;
            m_inv_vppn = bus.inv_vppn;
            m_vppn     = bus.csr_vppn;
            m_asid     = bus.csr_asid;
            m_idx      = (bus.op_code == 3'd3) ? fill_at(w) : bus.csr_index;
         end
         w++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 resetn = 1'b0;
      @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   initial begin
      int k;
      bus.op_valid = 1'b0; bus.op_code = '0; bus.flush = 1'b0; bus.inv_op = '0;
      bus.inv_asid = '0; bus.inv_vppn = '0; bus.csr_vppn = '0; bus.csr_asid = '0; bus.csr_index = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         tlb_vppn[i] = {1'b1, 18'($urandom)};
         tlb_asid[i] = 10'($urandom);
      end
      tlb_vppn[5] = 19'h00400;
      tlb_asid[5] = 10'h3;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_op_ready", bus.op_ready, 1'b0);
      chk("rst_we", bus.we, 1'b0);
      resetn = 1'b1;

      // srch hit on entry 5
      tick();
      bus.csr_vppn = 19'h00400; bus.csr_asid = 10'h3; bus.csr_index = 4'd0;
      bus.op_code = 3'd0; bus.op_valid = 1'b1;
      chk("srch_pre_sel", bus.s1_sel, 1'b0);
      chk("idle_ready", bus.op_ready, 1'b1);
      tick(); bus.op_valid = 1'b0;
      chk("srch_sel", bus.s1_sel, 1'b1);
      chk("srch_vppn", bus.s1_vppn, 19'h00400);
      chk("srch_asid", bus.s1_asid, 10'h3);
      tick();
      chk("srch_done", bus.done_valid, 1'b1);
      chk("srch_found", bus.done_found, 1'b1);
      chk("srch_index", bus.done_index, 4'd5);
      chk("srch_sel_off", bus.s1_sel, 1'b0);
      tick();
      chk("srch_pulse", bus.done_valid, 1'b0);
      chk("srch_ready", bus.op_ready, 1'b1);

      // illegal then legal invtlb
      bus.op_code = 3'd4; bus.inv_op = 5'd7; bus.inv_asid = 10'h1; bus.inv_vppn = 19'h2; bus.op_valid = 1'b1;
      tick(); bus.op_valid = 1'b0;
      chk("inv7_strobe", bus.invtlb_valid, 1'b0);
      chk("inv7_sel", bus.s1_sel, 1'b1);
      tick();
      chk("inv7_ine", bus.done_ine, 1'b1);
      chk("inv7_done", bus.done_valid, 1'b1);
      tick();
      bus.inv_op = 5'd2; bus.op_valid = 1'b1;
      tick(); bus.op_valid = 1'b0;
      chk("inv2_strobe", bus.invtlb_valid, 1'b1);
      chk("inv2_op", bus.invtlb_op, 5'd2);
      tick();
      chk("inv2_strobe_off", bus.invtlb_valid, 1'b0);
      chk("inv2_ine", bus.done_ine, 1'b0);
      tick();

      // back-to-back wr then rd with op_valid held
      bus.csr_index = 4'd9; bus.op_code = 3'd2; bus.op_valid = 1'b1;
      tick(); bus.op_code = 3'd1;
      chk("b2b_we", bus.we, 1'b1);
      chk("b2b_w_index", bus.w_index, 4'd9);
      chk("b2b_busy", bus.op_ready, 1'b0);
      tick();
      chk("b2b_wr_done", bus.done_op, 3'd2);
      chk("b2b_busy2", bus.op_ready, 1'b0);
      tick();
      chk("b2b_ready", bus.op_ready, 1'b1);
      tick(); bus.op_valid = 1'b0;
      chk("b2b_rd_no_we", bus.we, 1'b0);
      tick();
      chk("b2b_rd_done", bus.done_op, 3'd1);
      chk("b2b_r_index", bus.r_index, 4'd9);
      tick();

      // fill index from the generator, including wrap
      do_reset();
      repeat (20) tick();
      bus.op_code = 3'd3; bus.op_valid = 1'b1;
      tick(); bus.op_valid = 1'b0;
      chk("fill_we", bus.we, 1'b1);
`ifdef TLB_FILL_LFSR_EN
      chk("fill20_idx", bus.w_index, fill_at(20));
`else
      chk("fill20_idx", bus.w_index, 4'd4);
`endif
      tick(); tick();
      repeat (8) tick();
      bus.op_valid = 1'b1;
      tick(); bus.op_valid = 1'b0;
`ifndef TLB_FILL_LFSR_EN
      chk("fill31_idx", bus.w_index, 4'd15);
`endif
      tick(); tick();
      bus.op_valid = 1'b1;
      tick(); bus.op_valid = 1'b0;
`ifndef TLB_FILL_LFSR_EN
      chk("fill34_wrap_idx", bus.w_index, 4'd2);
`endif
      tick(); tick();

      // flush blocks accept in IDLE but not a running op
      bus.op_code = 3'd2; bus.op_valid = 1'b1; bus.flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("flush_idle_ready", bus.op_ready, 1'b1);
         chk("flush_idle_we", bus.we, 1'b0);
      end
      bus.flush = 1'b0;
      tick(); bus.flush = 1'b1; bus.op_valid = 1'b0;
      chk("flush_late_we", bus.we, 1'b1);
      tick();
      chk("flush_late_done", bus.done_valid, 1'b1);
      bus.flush = 1'b0;
      tick();

      // reserved op code
      bus.op_code = 3'd6; bus.op_valid = 1'b1;
      tick(); bus.op_valid = 1'b0;
      chk("rsv_no_we", bus.we, 1'b0);
      chk("rsv_no_sel", bus.s1_sel, 1'b0);
      tick();
      chk("rsv_ine", bus.done_ine, 1'b1);
      chk("rsv_done_op", bus.done_op, 3'd6);
      tick();

      // reset during EXEC of wr
      bus.op_code = 3'd2; bus.csr_index = 4'd7; bus.op_valid = 1'b1;
      tick(); bus.op_valid = 1'b0;
      chk("rstx_we_before", bus.we, 1'b1);
      #1 resetn = 1'b0;
      #1;
      chk("rstx_we_drop", bus.we, 1'b0);
      chk("rstx_w_index", bus.w_index, 4'd0);
      tick();
      chk("rstx_no_done", bus.done_valid, 1'b0);
      resetn = 1'b1;
      #1;
      chk("rstx_ready", bus.op_ready, 1'b1);
      tick();
      chk("rstx_no_done2", bus.done_valid, 1'b0);

      // random traffic against the model
      for (int n = 0; n < 2000; n++) begin
         tick();
         if (!resetn) resetn = 1'b1;
         else if ($urandom_range(149) == 0) resetn = 1'b0;
         bus.op_valid = ($urandom_range(9) < 6);
         k = $urandom_range(9);
         bus.op_code = (k < 8) ? 3'(k % 5) : 3'(5 + $urandom_range(2));
         bus.flush = ($urandom_range(7) == 0);
         bus.inv_op = 5'($urandom_range(7));
         bus.csr_index = IDXW'($urandom);
         if ($urandom_range(1) == 0) begin
            k = $urandom_range(TLBNUM - 1);
            bus.csr_vppn = tlb_vppn[k]; bus.csr_asid = tlb_asid[k];
         end else begin
            bus.csr_vppn = 19'($urandom); bus.csr_asid = 10'($urandom);
         end
         k = $urandom_range(TLBNUM - 1);
         bus.inv_vppn = ($urandom_range(1) == 0) ? tlb_vppn[k] : 19'($urandom);
         bus.inv_asid = ($urandom_range(1) == 0) ? tlb_asid[k] : 10'($urandom);
      end
      resetn = 1'b1;
      bus.op_valid = 1'b0;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tlb_op_sequencer.md
Name: tlb_op_sequencer

Overview:
- Sequences the TLB maintenance instructions issued from EXE: tlbsrch, tlbrd, tlbwr, tlbfill and invtlb.
- Owns the shared TLB s1 search port only while an op executes. The mmu muxes s1 between this block and memory-access translation using s1_sel.
- Drives the TLB read, write and invalidate ports, and keeps the fill-index generator.
- Returns a one-cycle done pulse with results to the CSR/WB logic.

Parameters:
- TLBNUM, 16: TLB entry count. IDXW = $clog2(TLBNUM) is a localparam.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- op_valid  in  1  EXE presents a TLB op
- op_ready  out  1  sequencer accepts the op this cycle
- op_code  in  3  0=srch, 1=rd, 2=wr, 3=fill, 4=inv; 5-7 reserved
- flush  in  1  pipeline flush (exception/ertn)
- inv_op  in  5  invtlb op field
- inv_asid  in  10  rj[9:0]
- inv_vppn  in  19  rk[31:13]
- csr_vppn  in  19  TLBEHI.VPPN
- csr_asid  in  10  ASID.ASID
- csr_index  in  IDXW  TLBIDX.INDEX
- s1_sel  out  1  sequencer owns the s1 port
- s1_vppn  out  19  search VPPN
- s1_va_bit12  out  1  search bit 12
- s1_asid  out  10  search ASID
- s1_found  in  1  TLB hit
- s1_index  in  IDXW  hit index
- r_index  out  IDXW  TLB read index
- we  out  1  TLB write strobe
- w_index  out  IDXW  TLB write index
- invtlb_valid  out  1  invalidate strobe
- invtlb_op  out  5  invalidate op
- done_valid  out  1  op complete, one-cycle pulse
- done_op  out  3  code of the completed op
- done_found  out  1  srch hit
- done_index  out  IDXW  srch hit index
- done_ine  out  1  invalid-instruction flag (bad inv_op or reserved op_code)

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0, fill generator 0. A reset in any state returns to IDLE immediately. No strobe may remain asserted after resetn falls.
- States:
  - IDLE → EXEC on accept. An accept is op_valid && !flush; op_ready = (state==IDLE). flush with op_valid in IDLE means no accept.
  - EXEC (1 cycle) → RESP.
  - RESP (1 cycle, done_valid=1) → IDLE.
- Latency: accept at T, port activity at T+1, done at T+2, next accept earliest at T+3.
- flush after accept is ignored. The accepted op always completes, because TLB side effects cannot be retracted.
- On accept, latch: op_code, inv_op, inv_asid, inv_vppn, csr_vppn, csr_asid, and the index.
  - Index is csr_index for rd/wr/srch, and the current fill-generator value for fill.
- EXEC, by op:
  - srch: s1_sel=1, s1_vppn=latched csr_vppn, s1_va_bit12=0, s1_asid=latched csr_asid. Capture s1_found and s1_index at the clock edge.
  - inv: s1_sel=1, s1_vppn=inv_vppn, s1_va_bit12=0, s1_asid=inv_asid, invtlb_valid=1, invtlb_op=inv_op. Only inv_op 0..6 are legal; for others invtlb_valid stays 0 and done_ine=1 in RESP.
  - wr/fill: we=1, w_index=latched index.
  - rd: no strobe.
- s1_sel and the s1 outputs are 0 outside EXEC.
- r_index is driven from the latched index in all states, so the CSR captures TLB read data when done_valid pulses.
- RESP: done_valid=1, done_op=latched op.
  - done_found/done_index are valid for srch only and 0 otherwise.
  - A reserved op_code completes with done_ine=1 and no strobes.
- Fill generator (default build):
  - Free-running counter, +1 every cycle.
  - Wraps TLBNUM-1 → 0.
  - Value sampled at the accept cycle.

Optional Feature:
- Macro TLB_FILL_LFSR_EN.
- When defined:
  - The fill index comes from an 8-bit Fibonacci LFSR: x^8+x^6+x^5+x^4+1, reset seed 8'h01, shifts every cycle.
  - fill index = lfsr[IDXW-1:0].
- When undefined: the wrapping counter described above. Port list is identical in both builds.

Test Plan:
- srch hit: csr_vppn=19'h00400, csr_asid=10'h3, TLB entry 5 matching → s1_sel=1 only at T+1; done at T+2 with done_found=1, done_index=5.
- inv_op=7: accept → invtlb_valid never 1, done_ine=1 at T+2. Repeat with inv_op=2: invtlb_valid=1, invtlb_op=2, for exactly one cycle.
- Back-to-back: op_valid held high with wr then rd, csr_index=9 → we=1, w_index=9 at T+1; second accept at T+3; r_index=9 at done T+5.
- Fill index (counter build): after reset, accept fill at cycle 20 → w_index=20 mod 16=4. Counter check continues 15→0 wrap.
- flush with op_valid in IDLE → op_ready stays 1, no accept, no strobes. flush at T+1 → op still completes, done at T+2.
- resetn asserted low during EXEC of wr → we drops immediately, state IDLE, no done pulse, op_ready=1 after release.
